seg_scan4: RTL and testbench

SEG_SCAN4 -- requirements
Module: seg_scan4

---
 rtl/seg_scan4.sv | 103 ++++++++++
 tb/tb_seg_scan4.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan4.sv
// Multiplexed 4-digit 7-segment scanner: one digit per SCAN_DIV-cycle slot with a
// BLANK-cycle dark lead-in per slot; dig/smg are registered (1 cycle after slot state).
module seg_scan4 #(
  parameter int SCAN_DIV = 12000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic        lz_en,
  output logic [3:0]  dig,
  output logic [7:0]  smg,
  output logic        frame_done
);

  localparam logic [15:0] CNT_MAX   = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK);

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp;
  logic        sh_lz;

  logic        wrap;
  logic [3:0]  nib;
  logic        lz_blank;
  logic [3:0]  dig_nxt;
  logic [7:0]  smg_nxt;

  // Segment pattern in A..G order, bit 6 = A down to bit 0 = G.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h7E;
      4'h1: seg7 = 7'h30;
      4'h2: seg7 = 7'h6D;
      4'h3: seg7 = 7'h79;
      4'h4: seg7 = 7'h33;
      4'h5: seg7 = 7'h5B;
      4'h6: seg7 = 7'h5F;
      4'h7: seg7 = 7'h70;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h7B;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h1F;
      4'hC: seg7 = 7'h4E;
      4'hD: seg7 = 7'h3D;
      4'hE: seg7 = 7'h4F;
      default: seg7 = 7'h47;
    endcase
  endfunction

  assign wrap = (cnt == CNT_MAX);

  always_comb begin
    nib      = sh_data[{idx, 2'b00} +: 4];
    lz_blank = 1'b0;
    dig_nxt  = 4'b1111;
    smg_nxt  = 8'h00;
    // A digit is a leading zero only if it and every digit to its left are zero.
    case (idx)
      2'd3:    lz_blank = sh_lz && (sh_data[15:12] == 4'h0);
      2'd2:    lz_blank = sh_lz && (sh_data[15:8] == 8'h00);
      2'd1:    lz_blank = sh_lz && (sh_data[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    if (cnt >= BLANK_END) begin
      dig_nxt = ~(4'b0001 << idx);
      smg_nxt = {sh_dp[idx], lz_blank ? 7'h00 : seg7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh_data    <= data;
      sh_dp      <= dp;
      sh_lz      <= lz_en;
      frame_done <= 1'b0;
      dig        <= 4'b1111;
      smg        <= 8'h00;
    end else begin
      dig        <= dig_nxt;
      smg        <= smg_nxt;
      frame_done <= wrap && (idx == 2'd3);
      if (wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        // Inputs are sampled only between frames so a frame never mixes two values.
        if (idx == 2'd3) begin
          sh_data <= data;
          sh_dp   <= dp;
          sh_lz   <= lz_en;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan4.sv
// Bench for seg_scan4 (SCAN_DIV=8, BLANK=2): frame-position reference model feeds an
// expected-value queue each cycle; every DUT output cycle is popped and compared.
module tb_seg_scan4;

  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lz_en;
  logic [3:0]  dig;
  logic [7:0]  smg;
  logic        frame_done;

  seg_scan4 #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .lz_en      (lz_en),
    .dig        (dig),
    .smg        (smg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table (P=0), indexed by hex value.
  logic [7:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 8'h7E; seg_tab[1]  = 8'h30; seg_tab[2]  = 8'h6D; seg_tab[3]  = 8'h79;
    seg_tab[4]  = 8'h33; seg_tab[5]  = 8'h5B; seg_tab[6]  = 8'h5F; seg_tab[7]  = 8'h70;
    seg_tab[8]  = 8'h7F; seg_tab[9]  = 8'h7B; seg_tab[10] = 8'h77; seg_tab[11] = 8'h1F;
    seg_tab[12] = 8'h4E; seg_tab[13] = 8'h3D; seg_tab[14] = 8'h4F; seg_tab[15] = 8'h47;
  end

  int          vectors;
  int          miscompares;
  logic [12:0] exp_q [$];

  // Model state: position within the frame and the snapshot the DUT should be showing.
  int          m_pos;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_lz;

  function automatic logic [12:0] model_out();
    int         d;
    int         off;
    logic [3:0] dg;
    logic [7:0] sg;
    logic [3:0] n;
    d   = m_pos / SD;
    off = m_pos % SD;
    dg  = 4'b1111;
    sg  = 8'h00;
    if (off >= BL) begin
      dg    = 4'b1111;
      dg[d] = 1'b0;
      n     = 4'((m_data >> (4 * d)) & 16'hF);
      sg    = seg_tab[n];
      if (m_lz && d > 0 && (m_data >> (4 * d)) == 16'h0) sg = 8'h00;
      sg[7] = m_dp[d];
    end
    return {dg, sg, (m_pos == FRAME - 1)};
  endfunction

  task automatic step(input string tag);
    logic [12:0] e;
    logic [12:0] got;
    if (rst) e = {4'b1111, 8'h00, 1'b0};
    else     e = model_out();
    exp_q.push_back(e);
    if (rst || m_pos == FRAME - 1) begin
      m_data = data;
      m_dp   = dp;
      m_lz   = lz_en;
    end
    m_pos = rst ? 0 : (m_pos + 1) % FRAME;
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {dig, smg, frame_done};
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: dig/smg/fd observed %b/%h/%b expected %b/%h/%b",
             tag, got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_pos       = 0;
    m_data      = '0;
    m_dp        = '0;
    m_lz        = 1'b0;

    // Basic scan of 1234 with no blanking or decimal points.
    rst = 1'b1; data = 16'h1234; dp = 4'b0000; lz_en = 1'b0;
    run("reset", 3);
    rst = 1'b0;
    run("scan_1234", 2 * FRAME);

    // Leading-zero blanking with a decimal point on digit 1.
    rst = 1'b1; data = 16'h00A0; dp = 4'b0010; lz_en = 1'b1;
    run("reset2", 1);
    rst = 1'b0;
    run("lz_00A0", FRAME);

    // All zero: only digit 0 shows; dp on a blanked digit still lights.
    rst = 1'b1; data = 16'h0000; dp = 4'b0000; lz_en = 1'b1;
    run("reset3", 1);
    rst = 1'b0;
    run("lz_0000", FRAME);
    dp = 4'b1000;
    run("lz_0000_dp3", 2 * FRAME);

    // Mid-frame input change must wait for the frame boundary.
    rst = 1'b1; data = 16'h1111; dp = 4'b0000; lz_en = 1'b0;
    run("reset4", 1);
    rst = 1'b0;
    run("hold_1111", 2 * SD + BL + 2);
    data = 16'h2222;
    run("hold_2222", 2 * FRAME);

    // Reset while digit 2 is lit aborts the scan and re-captures inputs.
    data = 16'hFEDC;
    rst  = 1'b1;
    run("mid_reset", 1);
    rst = 1'b0;
    run("sweep_FEDC", FRAME);
    data = 16'hBA98;
    dp   = 4'b0101;
    run("sweep_BA98", 2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
